clk_div_multi: RTL

- Multi-channel programmable clock divider and tick generator, clocked from the 100 MHz board clock.
- Each channel produces two outputs, both registered:
  - a divided "clock" level, used as a logic signal/enable, never as a clock net;
  - a single-cycle tick at the start of each period.
- Divide ratios change at run time without glitches, and all channels can be phase-aligned on command.
- Serves VGA pixel timing (divide-by-4 gives 25 MHz), game-logic ticks and display refresh.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 64 ++++++
 rtl/clk_div_multi.sv | 37 +++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int MIN_DIV     = 2;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_DIV_VAL = 4;

  // High-phase length: ceil(N/2), so odd ratios get the extra cycle high.
  function automatic logic [31:0] half_hi(input logic [31:0] n);
    return n - (n >> 1);
  endfunction

  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    return (v < 32'(MIN_DIV)) ? 32'(MIN_DIV) : v;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active/pending ratio, phase counter, registered level and tick.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  logic [CNT_W-1:0] n_act, n_pend, p;
  logic [CNT_W-1:0] load_val, n_next, p_next, h_next;
  logic             at_end, wrap, pend_next;

  always_comb begin
    load_val = CNT_W'(clamp_div(32'(div_val)));
    at_end   = (p == n_act - CNT_W'(1));
    wrap     = en & (sync | at_end);

    // A load landing on a period boundary wins over any older pending ratio.
    n_next = n_act;
    if (wrap) begin
      if (load)      n_next = load_val;
      else if (pend) n_next = n_pend;
    end

    p_next = p;
    if (wrap)    p_next = '0;
    else if (en) p_next = p + CNT_W'(1);

    pend_next = pend;
    if (wrap)      pend_next = 1'b0;
    else if (load) pend_next = 1'b1;

    h_next = CNT_W'(half_hi(32'(n_next)));
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      n_act   <= CNT_W'(DEF_DIV);
      n_pend  <= CNT_W'(DEF_DIV);
      p       <= CNT_W'(DEF_DIV - 1);
      pend    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      n_act <= n_next;
      p     <= p_next;
      pend  <= pend_next;
      tick  <= wrap;
      if (load && !wrap) n_pend <= load_val;
      if (en) clk_out <= (p_next < h_next);
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator on the 100 MHz board clock.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic                    clk_100mhz,
  input  logic                    rst,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    sync_all,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pend
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_100mhz (clk_100mhz),
      .rst        (rst),
      .en         (ch_en[i]),
      .sync       (sync_all),
      .load       (div_load[i]),
      .div_val    (div_val[i*CNT_W +: CNT_W]),
      .clk_out    (clk_out[i]),
      .tick       (tick[i]),
      .pend       (pend[i])
    );
  end

endmodule
